updown: RTL and testbench
=========================

UPDOWN -- requirements
Module: updown

Interface
- REQ-001 Parameter WIDTH, default 4: bit width of din and count.
- REQ-002 clock  input  1  sole clock; all state updates on its rising edge.
- REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clock.
- REQ-004 din  input  WIDTH  parallel load value.
- REQ-005 load  input  1  active-high; when asserted, count takes din on the next rising edge.
- REQ-006 up_down  input  1  direction select: 1 = count up, 0 = count down.
- REQ-007 count  output  WIDTH  current counter value, driven directly from a register with no combinational path from inputs.

Function
- REQ-008 Per-edge priority SHALL be: reset, then load, then count.
- REQ-009 With reset=0, load=1: count SHALL equal din after the edge, regardless of up_down.
- REQ-010 With reset=0, load=0, up_down=1: count SHALL become count+1 modulo 2^WIDTH.
- REQ-011 With reset=0, load=0, up_down=0: count SHALL become count-1 modulo 2^WIDTH.
- REQ-012 Latency: every input change SHALL take effect in count exactly one clock edge later.
- REQ-013 Up wrap-around: count 2^WIDTH-1 counting up SHALL go to 0.
- REQ-014 Down wrap-around: count 0 counting down SHALL go to 2^WIDTH-1.
- REQ-015 The counter SHALL change on every edge; there is no hold/enable state.
- REQ-016 up_down SHALL be sampled each edge; toggling it reverses direction starting at the next edge, with no lost or extra step.
- REQ-017 X/Z on load or up_down is outside the legal stimulus; count behaviour under X/Z is unspecified.

Reset
- REQ-018 reset=1 at a rising edge SHALL set count to 0, overriding load and up_down.
- REQ-019 Reset asserted mid-count SHALL clear count at that edge; counting resumes from 0 on the first edge with reset=0.
- REQ-020 There SHALL be no asynchronous reset path; count is undefined before the first reset edge.

Configuration
- REQ-021 Macro UPDOWN_SATURATE_EN SHALL select saturating behaviour at compile time.
- REQ-022 When UPDOWN_SATURATE_EN is defined, counting up at 2^WIDTH-1 SHALL hold at 2^WIDTH-1.
- REQ-023 When UPDOWN_SATURATE_EN is defined, counting down at 0 SHALL hold at 0.
- REQ-024 When UPDOWN_SATURATE_EN is defined, load and reset behaviour SHALL be unchanged.
- REQ-025 When UPDOWN_SATURATE_EN is not defined (default), wrap-around per REQ-013 and REQ-014 SHALL apply.

Verification (WIDTH=4, default build)
- REQ-026 Reset: reset=1 for 1 edge with load=1, din=9 -> count=0.
- REQ-027 Load then count up: load din=5, then load=0, up_down=1 for 3 edges -> count=5, 6, 7, 8.
- REQ-028 Up wrap: load 14, count up 3 edges -> count=15, 0, 1.
- REQ-029 Down wrap: load 1, up_down=0 for 3 edges -> count=0, 15, 14.
- REQ-030 Load over direction: count=3, load=1, din=12, up_down=0 -> count=12; next edge with load=0 -> count=11.
- REQ-031 Saturation build: load 15 and count up 2 edges -> count=15, 15; load 0 and count down -> count=0.

Source files
------------

// File: rtl/updown.sv
// Loadable up/down counter with synchronous reset; priority is reset, load, count.
// Define UPDOWN_SATURATE_EN to clamp at the end values instead of wrapping.
module updown #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             load,
  input  logic             up_down,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] MAXV = '1;

  logic at_max, at_min;
  assign at_max = (count == MAXV);
  assign at_min = (count == '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= din;
    end else if (up_down) begin
`ifdef UPDOWN_SATURATE_EN
      if (!at_max) count <= count + ONE;
`else
      count <= count + ONE;
`endif
    end else begin
`ifdef UPDOWN_SATURATE_EN
      if (!at_min) count <= count - ONE;
`else
      count <= count - ONE;
`endif
    end
  end

  // End-value flags are only consumed by the saturating build.
  logic unused_flags;
  assign unused_flags = at_max ^ at_min;

endmodule

// File: tb/tb_updown.sv
// Directed bench for updown (WIDTH=4); end-value expectations follow UPDOWN_SATURATE_EN.
module tb_updown;
  localparam int WIDTH = 4;
`ifdef UPDOWN_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic             clock = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] din;
  logic             load;
  logic             up_down;
  logic [WIDTH-1:0] count;

  int checks   = 0;
  int failures = 0;

  updown #(.WIDTH(WIDTH)) dut (
    .clock  (clock),
    .reset  (reset),
    .din    (din),
    .load   (load),
    .up_down(up_down),
    .count  (count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: count=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Apply inputs, take one rising edge, then sample just after it.
  task automatic step(input logic r, input logic l, input logic ud, input logic [WIDTH-1:0] d,
                      input string tag, input logic [WIDTH-1:0] exp);
    reset = r; load = l; up_down = ud; din = d;
    @(posedge clock);
    #1;
    chk(tag, count, exp);
  endtask

  initial begin
    reset = 1'b0; load = 1'b0; up_down = 1'b0; din = '0;
    @(negedge clock);

    step(1, 1, 1, 4'd9,  "reset_over_load", 4'd0);

    step(0, 1, 1, 4'd5,  "load5",   4'd5);
    step(0, 0, 1, 4'd0,  "up6",     4'd6);
    step(0, 0, 1, 4'd0,  "up7",     4'd7);
    step(0, 0, 1, 4'd0,  "up8",     4'd8);

    step(0, 1, 1, 4'd14, "load14",  4'd14);
    step(0, 0, 1, 4'd0,  "up15",    4'd15);
    step(0, 0, 1, 4'd0,  "up_wrap", SAT ? 4'd15 : 4'd0);
    step(0, 0, 1, 4'd0,  "up_after_wrap", SAT ? 4'd15 : 4'd1);

    step(0, 1, 0, 4'd1,  "load1",   4'd1);
    step(0, 0, 0, 4'd0,  "dn0",     4'd0);
    step(0, 0, 0, 4'd0,  "dn_wrap", SAT ? 4'd0 : 4'd15);
    step(0, 0, 0, 4'd0,  "dn_after_wrap", SAT ? 4'd0 : 4'd14);

    step(0, 1, 1, 4'd3,  "load3",   4'd3);
    step(0, 1, 0, 4'd12, "load_over_dir", 4'd12);
    step(0, 0, 0, 4'd0,  "dn11",    4'd11);

    step(0, 0, 1, 4'd0,  "toggle_up",   4'd12);
    step(0, 0, 0, 4'd0,  "toggle_dn",   4'd11);
    step(0, 0, 1, 4'd0,  "toggle_up2",  4'd12);

    step(1, 0, 1, 4'd0,  "reset_mid",   4'd0);
    step(0, 0, 1, 4'd0,  "resume_up",   4'd1);
    step(1, 0, 0, 4'd0,  "reset_again", 4'd0);
    step(0, 0, 0, 4'd0,  "resume_dn",   SAT ? 4'd0 : 4'd15);

    step(0, 1, 1, 4'd15, "load15",  4'd15);
    step(0, 0, 1, 4'd0,  "max_up1", SAT ? 4'd15 : 4'd0);
    step(0, 0, 1, 4'd0,  "max_up2", SAT ? 4'd15 : 4'd1);
    step(0, 1, 0, 4'd0,  "load0",   4'd0);
    step(0, 0, 0, 4'd0,  "min_dn",  SAT ? 4'd0 : 4'd15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL timeout: run did not complete");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
